branch_flag_eval: RTL and testbench
===================================

BRANCH_FLAG_EVAL -- requirements
Module: branch_flag_eval

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 The block SHALL expose these ports (name, direction, width, meaning):
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  compare result presented
- in_ready  out  1  block can accept a compare result
- alu_sel  in  4  ALU operation code of the compare
- funct3  in  3  RV32I branch funct3
- negative  in  1  ALU sign flag
- borrow  in  1  ALU borrow flag (1 = rs1 < rs2 unsigned)
- carry_out  in  1  ALU carry flag (ignored)
- overflow  in  1  ALU signed-overflow flag
- zero  in  1  ALU result == 0
- out_valid  out  1  decision held on outputs
- out_ready  in  1  consumer takes decision
- taken  out  1  branch taken
- branch_err  out  1  compare not usable for this branch
- cnt_clr  in  1  synchronous counter clear
- eval_cnt  out  16  decisions delivered
- taken_cnt  out  16  taken decisions delivered

Function
REQ-003 The FSM SHALL have two states: IDLE and RESP.
REQ-004 In IDLE: in_ready=1, out_valid=0; in_valid=1 SHALL capture the decision and move to RESP on the next edge.
REQ-005 In RESP: out_valid=1, and in_ready SHALL equal out_ready.
REQ-006 In RESP, if out_ready=1 and in_valid=1, the block SHALL load the new decision and remain in RESP (back-to-back, one decision per cycle).
REQ-007 In RESP, if out_ready=1 and in_valid=0, the block SHALL return to IDLE.
REQ-008 In RESP, if out_ready=0, taken and branch_err SHALL hold stable and input SHALL NOT be captured.
REQ-009 Latency SHALL be one cycle: a capture at edge N drives out_valid/taken from edge N onward.
REQ-010 A decision SHALL be valid only when alu_sel=4'b1000 (subtract); any other alu_sel SHALL register taken=0, branch_err=1.
REQ-011 With alu_sel=4'b1000, funct3 SHALL map as follows:
- 000 BEQ: zero
- 001 BNE: !zero
- 100 BLT: negative^overflow
- 101 BGE: !(negative^overflow)
- 110 BLTU: borrow
- 111 BGEU: !borrow
REQ-012 funct3 = 010 or 011 SHALL register taken=0, branch_err=1; all valid cases register branch_err=0.
REQ-013 carry_out SHALL NOT affect any output.
REQ-014 A decision is delivered when out_valid & out_ready; each delivery SHALL increment eval_cnt by 1, and also taken_cnt if taken=1.
REQ-015 Both counters SHALL saturate at 16'hFFFF (no wrap-around).
REQ-016 cnt_clr=1 SHALL zero both counters on the next edge; if it coincides with a delivery, clear SHALL win (counters read 0).
REQ-017 cnt_clr SHALL NOT affect FSM state, taken or branch_err.
REQ-018 Flag inputs SHALL be sampled only on a capture edge; flag changes at other times SHALL have no effect.

Reset
REQ-019 rst_n=0 SHALL immediately (asynchronously) force:
- state IDLE
- out_valid=0, taken=0, branch_err=0
- eval_cnt=0, taken_cnt=0
- in_ready=1 while in reset
REQ-020 Reset asserted in RESP SHALL discard the held decision without counting it.
REQ-021 Release of rst_n SHALL take effect at the next rising clk edge; the first capture SHALL be possible on that edge.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Unsigned vs signed compare: alu_sel=1000, funct3=110, borrow=1, out_ready=1 -> next cycle out_valid=1, taken=1, branch_err=0; eval_cnt=1, taken_cnt=1 after delivery. Repeat with funct3=100, negative=1, overflow=1 -> taken=0.
- Invalid compare: alu_sel=0000, funct3=000, zero=1 -> taken=0, branch_err=1, taken_cnt unchanged, eval_cnt increments.
- Backpressure: capture BNE (zero=0) with out_ready=0 for 3 cycles while flags toggle -> taken stays 1, in_ready=0, counters unchanged; then out_ready=1 -> one delivery, eval_cnt +1.
- Back-to-back: in_valid=1 and out_ready=1 for 4 cycles with BEQ/BNE alternating -> 4 deliveries in 4 cycles, FSM stays RESP, eval_cnt=4.
- Saturation and clear: preload to 16'hFFFE, deliver 2 taken -> both counters 16'hFFFF; cnt_clr coincident with a delivery -> both 0.
- Mid-operation reset: rst_n=0 asynchronously while in RESP -> out_valid=0 and counters 0 without waiting for a clk edge; after release, first capture works.

Source files
------------

// File: rtl/branch_flag_eval.sv
// RV32I branch decision stage: turns ALU compare flags plus funct3 into a taken/error
// decision held behind a valid/ready handshake, with saturating delivery counters.
module branch_flag_eval (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alu_sel,
  input  logic [2:0]  funct3,
  input  logic        negative,
  input  logic        borrow,
  input  logic        carry_out,
  input  logic        overflow,
  input  logic        zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        taken,
  output logic        branch_err,
  input  logic        cnt_clr,
  output logic [15:0] eval_cnt,
  output logic [15:0] taken_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [0:0] state;
  logic       capture;
  logic       deliver;
  logic [1:0] decision;
  logic       unused_carry;

  // Returns {branch_err, taken}; only a subtract compare with a defined funct3 is usable.
  function automatic logic [1:0] decide(
    input logic [3:0] sel,
    input logic [2:0] f3,
    input logic       n,
    input logic       b,
    input logic       v,
    input logic       z
  );
    logic [1:0] res;
    if (sel != ALU_SUB) begin
      res = 2'b10;
    end else begin
      case (f3)
        3'b000:  res = {1'b0, z};
        3'b001:  res = {1'b0, ~z};
        3'b100:  res = {1'b0, n ^ v};
        3'b101:  res = {1'b0, ~(n ^ v)};
        3'b110:  res = {1'b0, b};
        3'b111:  res = {1'b0, ~b};
        default: res = 2'b10;
      endcase
    end
    return res;
  endfunction

  assign unused_carry = carry_out;

  // Handshake decode; in RESP a new compare is accepted only as the held one drains.
  always_comb begin
    out_valid = (state == RESP);
    if (state == IDLE) begin
      in_ready = 1'b1;
    end else begin
      in_ready = out_ready;
    end
    capture  = in_valid & in_ready;
    deliver  = out_valid & out_ready;
    decision = decide(alu_sel, funct3, negative, borrow, overflow, zero);
  end

  // Two-state hold register for the decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      taken      <= 1'b0;
      branch_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            state      <= RESP;
            taken      <= decision[0];
            branch_err <= decision[1];
          end
        end
        RESP: begin
          if (capture) begin
            taken      <= decision[0];
            branch_err <= decision[1];
          end else if (deliver) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating delivery counters; a clear beats a coincident delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eval_cnt  <= 16'h0000;
      taken_cnt <= 16'h0000;
    end else if (cnt_clr) begin
      eval_cnt  <= 16'h0000;
      taken_cnt <= 16'h0000;
    end else if (deliver) begin
      if (eval_cnt != CNT_MAX) begin
        eval_cnt <= eval_cnt + 16'h0001;
      end
      if (taken && (taken_cnt != CNT_MAX)) begin
        taken_cnt <= taken_cnt + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_branch_flag_eval.sv
// Randomized and directed bench for branch_flag_eval against a transaction-level model.
module tb_branch_flag_eval;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_sel = 4'h0;
  logic [2:0]  funct3 = 3'h0;
  logic        negative = 1'b0;
  logic        borrow = 1'b0;
  logic        carry_out = 1'b0;
  logic        overflow = 1'b0;
  logic        zero = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        taken;
  logic        branch_err;
  logic        cnt_clr = 1'b0;
  logic [15:0] eval_cnt;
  logic [15:0] taken_cnt;

  int n_checks = 0;
  int n_fail = 0;

  // Reference state: is a decision held, what it says, and how many were delivered.
  bit m_hold = 1'b0;
  bit m_taken = 1'b0;
  bit m_err = 1'b0;
  int m_ev = 0;
  int m_tk = 0;

  branch_flag_eval dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_sel(alu_sel), .funct3(funct3), .negative(negative), .borrow(borrow),
    .carry_out(carry_out), .overflow(overflow), .zero(zero),
    .out_valid(out_valid), .out_ready(out_ready), .taken(taken),
    .branch_err(branch_err), .cnt_clr(cnt_clr), .eval_cnt(eval_cnt),
    .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // {err, taken}: equal / signed-less / unsigned-less relation, inverted by funct3 bit 0.
  function automatic logic [1:0] ref_decide(input int alu, input int f3, input bit n,
                                            input bit b, input bit v, input bit z);
    bit cond;
    if (alu != 8 || f3 == 2 || f3 == 3) return 2'b10;
    case (f3 >> 1)
      0: cond = z;
      2: cond = (n != v);
      3: cond = b;
      default: cond = 1'b0;
    endcase
    return {1'b0, cond ^ ((f3 & 1) != 0)};
  endfunction

  task automatic set_in(input bit iv, input int alu, input int f3, input bit n,
                        input bit b, input bit c, input bit v, input bit z, input bit ordy);
    in_valid = iv; alu_sel = alu[3:0]; funct3 = f3[2:0];
    negative = n; borrow = b; carry_out = c; overflow = v; zero = z; out_ready = ordy;
  endtask

  // One clock: check ready before the edge, advance the model, check outputs after it.
  task automatic cycle();
    bit exp_rdy, cap, dlv;
    logic [1:0] d;
    #1;
    exp_rdy = !m_hold || out_ready;
    check_eq("in_ready", in_ready, exp_rdy);
    cap = in_valid && exp_rdy;
    dlv = m_hold && out_ready;
    d = ref_decide(alu_sel, funct3, negative, borrow, overflow, zero);
    @(posedge clk);
    if (cnt_clr) begin
      m_ev = 0; m_tk = 0;
    end else if (dlv) begin
      if (m_ev < 65535) m_ev++;
      if (m_taken && m_tk < 65535) m_tk++;
    end
    if (cap) begin
      m_hold = 1'b1; m_taken = d[0]; m_err = d[1];
    end else if (dlv) begin
      m_hold = 1'b0;
    end
    #1;
    check_eq("out_valid", out_valid, m_hold);
    if (m_hold) begin
      check_eq("taken", taken, m_taken);
      check_eq("branch_err", branch_err, m_err);
    end
    check_eq("eval_cnt", eval_cnt, m_ev);
    check_eq("taken_cnt", taken_cnt, m_tk);
  endtask

  task automatic model_reset();
    m_hold = 1'b0; m_taken = 1'b0; m_err = 1'b0; m_ev = 0; m_tk = 0;
  endtask

  initial begin
    int ev0;
    #12;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_taken", taken, 1'b0);
    check_eq("rst_err", branch_err, 1'b0);
    check_eq("rst_eval", eval_cnt, 16'h0000);
    check_eq("rst_tkcnt", taken_cnt, 16'h0000);
    @(negedge clk); rst_n = 1'b1;

    // Unsigned then signed compare, then an unusable compare.
    set_in(1, 8, 6, 0, 1, 0, 0, 0, 1); cycle();
    check_eq("bltu_taken", taken, 1'b1);
    check_eq("bltu_err", branch_err, 1'b0);
    set_in(1, 8, 4, 1, 0, 1, 1, 0, 1); cycle();
    check_eq("blt_taken", taken, 1'b0);
    check_eq("bltu_eval", eval_cnt, 16'd1);
    check_eq("bltu_tkcnt", taken_cnt, 16'd1);
    set_in(1, 0, 0, 0, 0, 0, 0, 1, 1); cycle();
    check_eq("inv_taken", taken, 1'b0);
    check_eq("inv_err", branch_err, 1'b1);
    set_in(0, 8, 0, 0, 0, 0, 0, 0, 1); cycle();
    check_eq("inv_eval", eval_cnt, 16'd3);
    check_eq("inv_tkcnt", taken_cnt, 16'd1);

    // Backpressure with flags and in_valid toggling underneath.
    set_in(1, 8, 1, 0, 0, 0, 0, 0, 0); cycle();
    ev0 = eval_cnt;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 8, 1, i[0], ~i[0], 1, i[0], 1, 0); cycle();
      check_eq("bp_taken", taken, 1'b1);
      check_eq("bp_in_ready", in_ready, 1'b0);
      check_eq("bp_eval", eval_cnt, ev0);
    end
    set_in(0, 8, 0, 0, 0, 0, 0, 0, 1); cycle();
    check_eq("bp_deliver", eval_cnt, ev0 + 1);

    // Back-to-back BEQ/BNE after a clear.
    cnt_clr = 1'b1; set_in(0, 8, 0, 0, 0, 0, 0, 0, 0); cycle(); cnt_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(1, 8, i % 2, 0, 0, 0, 0, 1, 1); cycle();
      check_eq("b2b_valid", out_valid, 1'b1);
    end
    set_in(0, 8, 0, 0, 0, 0, 0, 0, 1); cycle();
    check_eq("b2b_eval", eval_cnt, 16'd4);
    check_eq("b2b_tkcnt", taken_cnt, 16'd2);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) != 0, ($urandom_range(0, 4) != 0) ? 8 : $urandom_range(0, 15),
             $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 2) != 0);
      cnt_clr = ($urandom_range(0, 19) == 0);
      cycle();
    end
    cnt_clr = 1'b0;

    // Saturation: preload both counters to FFFE with taken BEQs, then two more.
    cnt_clr = 1'b1; set_in(0, 8, 0, 0, 0, 0, 0, 0, 1); cycle(); cnt_clr = 1'b0;
    set_in(1, 8, 0, 0, 0, 0, 0, 1, 1);
    while (m_ev < 65534) cycle();
    check_eq("pre_eval", eval_cnt, 16'hFFFE);
    check_eq("pre_tkcnt", taken_cnt, 16'hFFFE);
    cycle(); cycle();
    check_eq("sat_eval", eval_cnt, 16'hFFFF);
    check_eq("sat_tkcnt", taken_cnt, 16'hFFFF);
    cycle();
    check_eq("sat_hold", eval_cnt, 16'hFFFF);
    cnt_clr = 1'b1; cycle(); cnt_clr = 1'b0;
    check_eq("clr_eval", eval_cnt, 16'h0000);
    check_eq("clr_tkcnt", taken_cnt, 16'h0000);
    check_eq("clr_state", out_valid, 1'b1);

    // Asynchronous reset while a decision is held.
    set_in(1, 8, 6, 0, 1, 0, 0, 0, 0); cycle();
    #2; rst_n = 1'b0; #1;
    check_eq("ar_out_valid", out_valid, 1'b0);
    check_eq("ar_taken", taken, 1'b0);
    check_eq("ar_in_ready", in_ready, 1'b1);
    check_eq("ar_eval", eval_cnt, 16'h0000);
    check_eq("ar_tkcnt", taken_cnt, 16'h0000);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    set_in(1, 8, 7, 0, 0, 0, 0, 0, 1); cycle();
    check_eq("post_rst_taken", taken, 1'b1);
    set_in(0, 8, 0, 0, 0, 0, 0, 0, 1); cycle();
    check_eq("post_rst_eval", eval_cnt, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
